fetch_stage: RTL and testbench
==============================

# fetch_stage

IF stage of the P5 pipeline: owns the program counter, fetches instructions from instruction memory through a req/rvalid handshake, and loads the IF/ID pipeline register. The next-PC logic consumes `f_pc4` and returns `next_pc`, which this block commits when the fetched instruction advances to D. Stalls come from the hazard unit. Misaligned or out-of-range PCs are turned into flagged NOPs.

## Interface
- `RESET_PC`, 32'h0000_3000, PC after reset
- `IM_BASE`, 32'h0000_3000, lowest legal instruction address
- `IM_WORDS`, 4096, legal range is `IM_BASE` .. `IM_BASE + 4*IM_WORDS - 4`

Ports:
- `clk  in  1  sole clock, rising edge`
- `reset  in  1  asynchronous, active-high`
- `next_pc  in  32  next PC from NPC, valid every cycle`
- `stall  in  1  hazard-unit stall: hold PC and IF/ID`
- `imem_req  out  1  fetch request`
- `imem_addr  out  32  word address, equals `f_pc` while `imem_req``
- `imem_rvalid  in  1  response valid; may rise in the cycle of `imem_req` or any later cycle`
- `imem_rdata  in  32  instruction, valid with `imem_rvalid``
- `f_pc  out  32  current PC`
- `f_pc4  out  32  `f_pc + 4`, wraps mod 2^32, to NPC `Addr``
- `d_ins  out  32  IF/ID instruction`
- `d_pc  out  32  IF/ID PC`
- `d_pc4  out  32  IF/ID PC+4`
- `d_valid  out  1  IF/ID holds a real instruction`
- `d_exc_adel  out  1  IF/ID instruction came from an illegal PC`

## Operation
- States: `FETCH`, `HOLD`. Reset enters `FETCH`.
- `bad_pc = f_pc[1:0] != 0 || f_pc < IM_BASE || f_pc > IM_BASE + 4*IM_WORDS - 4`.
- `FETCH`, `imem_req = !bad_pc`. An instruction is available when `imem_rvalid` is high, or when `bad_pc` is high (synthetic NOP, 32'h0, with the exception flag set).
  - Available and `!stall`: IF/ID loads `{instr, f_pc, f_pc4, valid=1, exc}`; `f_pc <= next_pc`; stay in `FETCH`.
  - Available and `stall`: capture into the hold buffer; go to `HOLD`; IF/ID unchanged.
  - Not available and `!stall`: IF/ID loads a bubble (`d_ins=0`, `d_valid=0`, `d_exc_adel=0`, `d_pc`/`d_pc4` = 0); PC unchanged.
  - Not available and `stall`: everything holds.
- `HOLD`, `imem_req=0`. `imem_rvalid` is ignored.
  - `!stall`: IF/ID loads the hold buffer; `f_pc <= next_pc`; go to `FETCH`.
  - Otherwise stay in `HOLD`.
- `next_pc` is sampled only on the edge where the instruction at `f_pc` enters IF/ID.
- At most one outstanding request.
- `imem_rvalid` with `imem_req` low, in `FETCH` or `HOLD`, is a protocol error; the response is dropped.

## Timing
- Reset values: `f_pc = RESET_PC`, `f_pc4 = RESET_PC + 4`, state `FETCH`.
  - IF/ID: `d_ins`, `d_pc`, `d_pc4` = 0; `d_valid = 0`; `d_exc_adel = 0`.
  - `imem_req` is 1 immediately if `RESET_PC` is legal.
- Reset asserted mid-wait: the outstanding request is abandoned. The first `imem_rvalid` after release is accepted only if `imem_req` is high.
- Single-cycle memory (`rvalid` in the same cycle as `req`), no stall: one instruction per cycle; IF/ID is updated on the edge ending the request cycle.
- N-cycle memory: N-1 bubbles per instruction.
- Stall has priority over advance. The hold buffer prevents a refetch, so the memory sees exactly one request per PC.
- `f_pc = 32'hFFFF_FFFC` gives `f_pc4 = 0` (wrap); it is also out of range, so it yields an exception NOP.

## Structure
- Shared package `p5_defs`:
  - constants `RESET_PC`, `IM_BASE`, `IM_WORDS`, `NOP = 32'h0`
  - state enum `FETCH` / `HOLD`
  - IF/ID record (ins, pc, pc4, valid, exc)
- One sub-module `if_id_reg`: IF/ID register with load/bubble/hold controls and async reset.
- Top level holds the PC register, `bad_pc` logic, FSM and hold buffer.

## Test plan
- Reset, single-cycle memory returns 32'h3C01_0001 at 0x3000 and 32'h3421_0002 at 0x3004, `next_pc = f_pc4`:
  - `d_pc` = 0x3000 then 0x3004 on consecutive edges, `d_valid` = 1.
- 3-cycle memory latency:
  - exactly two bubbles (`d_valid=0`) precede each instruction
  - `imem_req` stays high, `imem_addr` stable, until `rvalid`
- `stall` asserted in the `rvalid` cycle for 2 cycles:
  - state goes to `HOLD`, `imem_req=0`, IF/ID holds
  - after release the buffered instruction enters IF/ID with no second request to 0x3000
- `next_pc = 0x3002`:
  - no request
  - next IF/ID has `d_ins=0`, `d_valid=1`, `d_exc_adel=1`, `d_pc=0x3002`
- `next_pc = 0x7000` (past range) → same exception NOP; then `next_pc = 0x3000` → normal fetch resumes.
- Reset pulsed while waiting on a response:
  - `f_pc` returns to 0x3000 asynchronously, IF/ID clears
  - a stale `rvalid` arriving while `imem_req` is low is ignored

Source files
------------

// File: rtl/p5_defs.sv
// Shared definitions for the P5 pipeline front end: memory map, fetch FSM
// states and the IF/ID pipeline record.
package p5_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int unsigned IM_WORDS = 4096;
  // Highest word address that still holds an instruction.
  localparam logic [31:0] IM_LAST  = IM_BASE + (IM_WORDS * 32'd4) - 32'd4;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        exc;
  } ifid_t;

  // A PC is illegal when misaligned or outside the instruction memory window.
  function automatic logic pc_illegal(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load takes priority over bubble, otherwise hold.
module if_id_reg
  import p5_defs::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t din,
  output ifid_t dout
);

  ifid_t r_d, r_q;

  // Select between new record, bubble and hold.
  always_comb begin
    r_d = r_q;
    if (load) begin
      r_d = din;
    end else if (bubble) begin
      r_d = '0;
    end
  end

  // Register with asynchronous clear to an empty slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign dout = r_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: program counter, single-outstanding instruction fetch, hold
// buffer for stalled responses, and the IF/ID register.
module fetch_stage
  import p5_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] f_pc4,
  output logic [31:0] d_ins,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc4,
  output logic        d_valid,
  output logic        d_exc_adel
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  ifid_t        hold_q, hold_d;
  ifid_t        fetched, ifid_din, ifid_q;
  logic         bad_pc, avail, ifid_load, ifid_bubble;

  assign bad_pc    = pc_illegal(pc_q);
  assign f_pc      = pc_q;
  assign f_pc4     = pc_q + 32'd4;
  assign imem_req  = (state_q == FETCH) && !bad_pc;
  assign imem_addr = pc_q;

  // An illegal PC produces a flagged NOP instead of a memory access.
  assign fetched = '{ins:   bad_pc ? NOP : imem_rdata,
                     pc:    pc_q,
                     pc4:   f_pc4,
                     valid: 1'b1,
                     exc:   bad_pc};

  // Next-state, PC advance and IF/ID control; stall always wins over advance.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    ifid_din    = fetched;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    avail       = 1'b0;
    case (state_q)
      FETCH: begin
        // A response while no request is pending (bad_pc) is dropped: the
        // synthetic NOP is used regardless of imem_rdata.
        avail = bad_pc || imem_rvalid;
        if (avail) begin
          if (!stall) begin
            ifid_load = 1'b1;
            pc_d      = next_pc;
          end else begin
            hold_d  = fetched;
            state_d = HOLD;
          end
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
      end
      HOLD: begin
        // Memory is idle here; any stray response is ignored.
        if (!stall) begin
          ifid_din  = hold_q;
          ifid_load = 1'b1;
          pc_d      = next_pc;
          state_d   = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Control state: FSM and PC, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Hold buffer is only read after being written in FETCH, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  if_id_reg u_if_id (
    .clk    (clk),
    .reset  (reset),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .din    (ifid_din),
    .dout   (ifid_q)
  );

  assign d_ins      = ifid_q.ins;
  assign d_pc       = ifid_q.pc;
  assign d_pc4      = ifid_q.pc4;
  assign d_valid    = ifid_q.valid;
  assign d_exc_adel = ifid_q.exc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage with a latency-programmable
// instruction memory and a transaction-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] f_pc, f_pc4, d_ins, d_pc, d_pc4;
  logic        d_valid, d_exc_adel;

  int          n_tests = 0;
  int          n_fail  = 0;

  int          lat;
  int          wcnt;
  int          acc_cnt = 0;
  logic        force_rv;
  logic [31:0] force_data;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .next_pc     (next_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .f_pc        (f_pc),
    .f_pc4       (f_pc4),
    .d_ins       (d_ins),
    .d_pc        (d_pc),
    .d_pc4       (d_pc4),
    .d_valid     (d_valid),
    .d_exc_adel  (d_exc_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h3C01_0001;
    if (a == 32'h0000_3004) return 32'h3421_0002;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic legal(input logic [31:0] a);
    return (a % 32'd4 == 32'd0) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFC);
  endfunction

  // Memory answers a request after lat cycles (lat=1: same cycle).
  assign imem_rvalid = force_rv | (imem_req && (wcnt >= lat - 1));
  assign imem_rdata  = force_rv ? force_data : memf(imem_addr);

  // Wait counter of the memory model; a reset abandons the pending access.
  always @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (imem_req && !imem_rvalid) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Count completed request/response handshakes.
  always @(posedge clk) begin
    if (imem_req && imem_rvalid) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between clock edges.
  task automatic do_reset();
    #1 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  logic [97:0] prev, cur, expv;
  logic [31:0] exp_pc, np;
  logic        st;
  int          acc_mark, entries, r, a0, bubbles;

  initial begin
    reset = 1'b1; stall = 1'b0; next_pc = 32'h3004; lat = 1;
    force_rv = 1'b0; force_data = 32'h0;
    #12;
    // Reset state
    chk("rst_fpc",  {f_pc, f_pc4}, {32'h3000, 32'h3004});
    chk("rst_ifid", {d_ins, d_pc, d_pc4, d_valid, d_exc_adel}, 98'h0);
    chk("rst_req",  {imem_req, imem_addr}, {1'b1, 32'h3000});
    reset = 1'b0;

    // Single-cycle memory, sequential flow
    tick();
    chk("seq0", {d_ins, d_pc, d_pc4, d_valid, d_exc_adel},
        {32'h3C01_0001, 32'h3000, 32'h3004, 1'b1, 1'b0});
    chk("seq0_fpc", f_pc, 32'h3004);
    next_pc = 32'h3008;
    tick();
    chk("seq1", {d_ins, d_pc, d_pc4, d_valid, d_exc_adel},
        {32'h3421_0002, 32'h3004, 32'h3008, 1'b1, 1'b0});

    // Three-cycle memory: two bubbles per instruction, request held stable
    lat = 3; next_pc = 32'h3004;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk("lat3_req", {imem_req, imem_addr}, {1'b1, 32'h3000});
      tick();
      chk("lat3_bubble", {d_ins, d_pc, d_pc4, d_valid, d_exc_adel}, 98'h0);
    end
    chk("lat3_req", {imem_req, imem_addr}, {1'b1, 32'h3000});
    tick();
    chk("lat3_ins0", {d_ins, d_pc, d_valid}, {32'h3C01_0001, 32'h3000, 1'b1});
    next_pc = 32'h3008;
    bubbles = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (!d_valid) bubbles++;
    end
    chk("lat3_nbubbles", bubbles, 2);
    chk("lat3_ins1", {d_ins, d_pc, d_valid}, {32'h3421_0002, 32'h3004, 1'b1});

    // Stall in the response cycle for two cycles, stray response while held
    lat = 1; next_pc = 32'h3004;
    do_reset();
    a0 = acc_cnt;
    stall = 1'b1;
    tick();
    chk("stall_req0", imem_req, 1'b0);
    chk("stall_ifid", {d_ins, d_pc, d_valid}, 65'h0);
    chk("stall_acc", acc_cnt - a0, 1);
    force_rv = 1'b1; force_data = 32'hDEAD_BEEF;
    tick();
    chk("stall_req1", imem_req, 1'b0);
    chk("stall_ifid2", d_valid, 1'b0);
    force_rv = 1'b0; stall = 1'b0;
    tick();
    chk("stall_rel", {d_ins, d_pc, d_pc4, d_valid, d_exc_adel},
        {32'h3C01_0001, 32'h3000, 32'h3004, 1'b1, 1'b0});
    chk("stall_norefetch", acc_cnt - a0, 1);
    chk("stall_fpc", {f_pc, imem_req}, {32'h3004, 1'b1});
    next_pc = 32'h3008;
    tick();
    chk("stall_next", {d_ins, d_pc}, {32'h3421_0002, 32'h3004});

    // Misaligned, out-of-range and wrapping PCs
    next_pc = 32'h3002;
    tick();
    chk("mis_req", {f_pc, imem_req}, {32'h3002, 1'b0});
    next_pc = 32'h7000;
    tick();
    chk("mis_nop", {d_ins, d_pc, d_pc4, d_valid, d_exc_adel},
        {32'h0, 32'h3002, 32'h3006, 1'b1, 1'b1});
    chk("oor_req", {f_pc, imem_req}, {32'h7000, 1'b0});
    next_pc = 32'h3000;
    tick();
    chk("oor_nop", {d_ins, d_pc, d_pc4, d_valid, d_exc_adel},
        {32'h0, 32'h7000, 32'h7004, 1'b1, 1'b1});
    chk("resume_req", {imem_req, imem_addr}, {1'b1, 32'h3000});
    next_pc = 32'hFFFF_FFFC;
    tick();
    chk("resume_ins", {d_ins, d_pc, d_valid, d_exc_adel}, {32'h3C01_0001, 32'h3000, 1'b1, 1'b0});
    chk("wrap_pc4", {f_pc, f_pc4, imem_req}, {32'hFFFF_FFFC, 32'h0, 1'b0});
    force_rv = 1'b1; force_data = 32'h1234_5678;
    next_pc = 32'h3004;
    tick();
    force_rv = 1'b0;
    chk("wrap_nop", {d_ins, d_pc, d_pc4, d_valid, d_exc_adel},
        {32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1});

    // Reset while a three-cycle access is pending
    lat = 3;
    tick();
    chk("rmw_wait", {imem_req, imem_addr, d_valid}, {1'b1, 32'h3004, 1'b0});
    #2 reset = 1'b1;
    #1;
    chk("rmw_async", {f_pc, d_ins, d_pc, d_pc4, d_valid, d_exc_adel}, {32'h3000, 98'h0});
    reset = 1'b0;
    a0 = acc_cnt;
    tick(); tick();
    chk("rmw_bubbles", d_valid, 1'b0);
    tick();
    chk("rmw_first", {d_ins, d_pc, d_valid}, {32'h3C01_0001, 32'h3000, 1'b1});
    chk("rmw_acc", acc_cnt - a0, 1);

    // Randomized traffic against the transaction-level model
    do_reset();
    exp_pc = 32'h3000; acc_mark = acc_cnt; entries = 0;
    for (int k = 0; k < 1200; k++) begin
      if (k % 300 == 0) lat = k / 300 + 1;
      stall = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 19);
      if (r < 14) next_pc = exp_pc + 32'd4;
      else if (r < 17) next_pc = 32'h3000 + 32'd4 * $urandom_range(0, 4095);
      else next_pc = $urandom;
      prev = {d_ins, d_pc, d_pc4, d_valid, d_exc_adel};
      st = stall; np = next_pc;
      tick();
      cur = {d_ins, d_pc, d_pc4, d_valid, d_exc_adel};
      if (st) begin
        chk("rnd_hold", cur, prev);
      end else if (d_valid) begin
        expv = {legal(exp_pc) ? memf(exp_pc) : 32'h0, exp_pc, exp_pc + 32'd4,
                1'b1, !legal(exp_pc)};
        chk("rnd_entry", cur, expv);
        chk("rnd_one_req", acc_cnt - acc_mark, legal(exp_pc) ? 1 : 0);
        acc_mark = acc_cnt; exp_pc = np; entries++;
      end else begin
        chk("rnd_bubble", cur, 98'h0);
      end
      chk("rnd_fpc", {f_pc, f_pc4}, {exp_pc, exp_pc + 32'd4});
      if (imem_req) chk("rnd_addr", imem_addr, exp_pc);
      chk("rnd_req_legal", imem_req & ~legal(exp_pc), 1'b0);
    end
    chk("rnd_progress", entries > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
